// File: rtl/note_player_poly.sv
// Polyphonic note player: captures song-reader notes into free voice slots
// and counts each one down on the play-gated beat strobe.
module note_player_poly #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int META_W     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play,
    input  logic                         beat,
    input  logic                         new_note,
    input  logic [NOTE_W-1:0]            note,
    input  logic [NOTE_W-1:0]            duration,
    input  logic [META_W-1:0]            metadata,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_notes,
    output logic [NUM_VOICES*META_W-1:0] voice_meta,
    output logic                         note_done,
    output logic [NUM_VOICES-1:0]        done_mask,
    output logic                         overflow
);

    typedef enum logic {IDLE, PLAYING} voice_state_t;

    voice_state_t            state_q [NUM_VOICES];
    logic [NOTE_W-1:0]       note_q  [NUM_VOICES];
    logic [META_W-1:0]       meta_q  [NUM_VOICES];
    logic [NOTE_W-1:0]       rem_q   [NUM_VOICES];

    logic                    beat_en;
    logic                    alloc_req;
    logic [NUM_VOICES-1:0]   idle;
    logic [NUM_VOICES-1:0]   alloc_oh;
    logic [NUM_VOICES-1:0]   done_next;

    assign beat_en   = beat & play;
    assign alloc_req = new_note && (duration != '0);

    // Idle set reflects state before the edge, so a voice freeing on this
    // beat cannot be reused until the next edge.
    always_comb begin
        idle      = '0;
        done_next = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            idle[i]      = (state_q[i] == IDLE);
            done_next[i] = (state_q[i] == PLAYING) && beat_en && (rem_q[i] == NOTE_W'(1));
        end
        alloc_oh = idle & (~idle + NUM_VOICES'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= IDLE;
                note_q[i]  <= '0;
                meta_q[i]  <= '0;
                rem_q[i]   <= '0;
            end
            note_done <= 1'b0;
            done_mask <= '0;
            overflow  <= 1'b0;
        end else begin
            note_done <= |done_next;
            done_mask <= done_next;
            overflow  <= alloc_req && !(|idle);
            for (int i = 0; i < NUM_VOICES; i++) begin
                case (state_q[i])
                    IDLE: begin
                        if (alloc_req && alloc_oh[i]) begin
                            state_q[i] <= PLAYING;
                            note_q[i]  <= note;
                            meta_q[i]  <= metadata;
                            rem_q[i]   <= duration;
                        end
                    end
                    PLAYING: begin
                        if (beat_en) begin
                            if (rem_q[i] == NOTE_W'(1)) begin
                                state_q[i] <= IDLE;
                                note_q[i]  <= '0;
                                meta_q[i]  <= '0;
                                rem_q[i]   <= '0;
                            end else begin
                                rem_q[i] <= rem_q[i] - NOTE_W'(1);
                            end
                        end
                    end
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        voice_active = '0;
        voice_notes  = '0;
        voice_meta   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_active[i]                = (state_q[i] == PLAYING);
            voice_notes[i*NOTE_W +: NOTE_W] = note_q[i];
            voice_meta[i*META_W +: META_W]  = meta_q[i];
        end
    end

endmodule

// File: tb/tb_note_player_poly.sv
// Bench for note_player_poly: a 3-voice and a 1-voice instance share stimulus;
// expected outputs are queued with each cycle's stimulus and compared after the edge.
module tb_note_player_poly;

    logic        clk = 1'b0;
    logic        reset, play, beat, new_note;
    logic [5:0]  note, duration;
    logic [2:0]  metadata;

    logic [2:0]  act3, mask3;
    logic [17:0] notes3;
    logic [8:0]  meta3;
    logic        done3, ovf3;

    logic [0:0]  act1, mask1;
    logic [5:0]  notes1;
    logic [2:0]  meta1;
    logic        done1, ovf1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        one;
        logic [2:0]  act;
        logic [17:0] notes;
        logic [8:0]  meta;
        logic        done;
        logic [2:0]  mask;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    note_player_poly #(.NUM_VOICES(3), .NOTE_W(6), .META_W(3)) u_dut3 (
        .clk(clk), .reset(reset), .play(play), .beat(beat), .new_note(new_note),
        .note(note), .duration(duration), .metadata(metadata),
        .voice_active(act3), .voice_notes(notes3), .voice_meta(meta3),
        .note_done(done3), .done_mask(mask3), .overflow(ovf3)
    );

    note_player_poly #(.NUM_VOICES(1), .NOTE_W(6), .META_W(3)) u_dut1 (
        .clk(clk), .reset(reset), .play(play), .beat(beat), .new_note(new_note),
        .note(note), .duration(duration), .metadata(metadata),
        .voice_active(act1), .voice_notes(notes1), .voice_meta(meta1),
        .note_done(done1), .done_mask(mask1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic one, input logic [2:0] act, input logic [17:0] notes,
                                input logic [8:0] meta, input logic done, input logic [2:0] mask,
                                input logic ovf);
        exp_t e;
        e.one = one; e.act = act; e.notes = notes; e.meta = meta;
        e.done = done; e.mask = mask; e.ovf = ovf;
        return e;
    endfunction

    function automatic logic [17:0] pn(input int a, input int b, input int c);
        return {6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic logic [8:0] pm(input int a, input int b, input int c);
        return {3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic cyc(input string name, input logic rs, input logic nn, input int nt, input int du,
                       input int me, input logic bt, input logic pl, input exp_t e);
        exp_t ex;
        reset = rs; new_note = nn; note = 6'(nt); duration = 6'(du);
        metadata = 3'(me); beat = bt; play = pl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        if (ex.one) begin
            check({name, ".act1"},   32'(act1),   32'(ex.act));
            check({name, ".notes1"}, 32'(notes1), 32'(ex.notes));
            check({name, ".meta1"},  32'(meta1),  32'(ex.meta));
            check({name, ".done1"},  32'(done1),  32'(ex.done));
            check({name, ".mask1"},  32'(mask1),  32'(ex.mask));
            check({name, ".ovf1"},   32'(ovf1),   32'(ex.ovf));
        end else begin
            check({name, ".act"},    32'(act3),   32'(ex.act));
            check({name, ".notes"},  32'(notes3), 32'(ex.notes));
            check({name, ".meta"},   32'(meta3),  32'(ex.meta));
            check({name, ".done"},   32'(done3),  32'(ex.done));
            check({name, ".mask"},   32'(mask3),  32'(ex.mask));
            check({name, ".ovf"},    32'(ovf3),   32'(ex.ovf));
        end
    endtask

    initial begin
        exp_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0);

        // single note, three beats
        cyc("rst",   1, 0, 0, 0, 0, 0, 0, z);
        cyc("ld20",  0, 1, 20, 3, 5, 0, 1, mk(0, 3'b001, pn(20, 0, 0), pm(5, 0, 0), 0, 0, 0));
        cyc("hold",  0, 0, 0, 0, 0, 0, 1, mk(0, 3'b001, pn(20, 0, 0), pm(5, 0, 0), 0, 0, 0));
        cyc("s1b1",  0, 0, 0, 0, 0, 1, 1, mk(0, 3'b001, pn(20, 0, 0), pm(5, 0, 0), 0, 0, 0));
        cyc("s1b2",  0, 0, 0, 0, 0, 1, 1, mk(0, 3'b001, pn(20, 0, 0), pm(5, 0, 0), 0, 0, 0));
        cyc("s1b3",  0, 0, 0, 0, 0, 1, 1, mk(0, 3'b000, 0, 0, 1, 3'b001, 0));
        cyc("s1idl", 0, 0, 0, 0, 0, 0, 1, z);

        // chord of three with durations 2,4,1
        cyc("ld10",  0, 1, 10, 2, 1, 0, 1, mk(0, 3'b001, pn(10, 0, 0),   pm(1, 0, 0), 0, 0, 0));
        cyc("ld11",  0, 1, 11, 4, 2, 0, 1, mk(0, 3'b011, pn(10, 11, 0),  pm(1, 2, 0), 0, 0, 0));
        cyc("ld12",  0, 1, 12, 1, 3, 0, 1, mk(0, 3'b111, pn(10, 11, 12), pm(1, 2, 3), 0, 0, 0));
        cyc("s2b1",  0, 0, 0, 0, 0, 1, 1, mk(0, 3'b011, pn(10, 11, 0),  pm(1, 2, 0), 1, 3'b100, 0));
        cyc("s2b2",  0, 0, 0, 0, 0, 1, 1, mk(0, 3'b010, pn(0, 11, 0),   pm(0, 2, 0), 1, 3'b001, 0));
        cyc("s2b3",  0, 0, 0, 0, 0, 1, 1, mk(0, 3'b010, pn(0, 11, 0),   pm(0, 2, 0), 0, 0, 0));
        cyc("s2b4",  0, 0, 0, 0, 0, 1, 1, mk(0, 3'b000, 0, 0, 1, 3'b010, 0));
        cyc("s2idl", 0, 0, 0, 0, 0, 0, 1, z);

        // overflow on the fourth strobe, then reset while playing
        cyc("ov1",   0, 1, 1, 5, 0, 0, 1, mk(0, 3'b001, pn(1, 0, 0), 0, 0, 0, 0));
        cyc("ov2",   0, 1, 2, 5, 0, 0, 1, mk(0, 3'b011, pn(1, 2, 0), 0, 0, 0, 0));
        cyc("ov3",   0, 1, 3, 5, 0, 0, 1, mk(0, 3'b111, pn(1, 2, 3), 0, 0, 0, 0));
        cyc("ov4",   0, 1, 4, 5, 0, 0, 1, mk(0, 3'b111, pn(1, 2, 3), 0, 0, 0, 1));
        cyc("ov5",   0, 0, 0, 0, 0, 0, 1, mk(0, 3'b111, pn(1, 2, 3), 0, 0, 0, 0));
        cyc("rstp",  1, 0, 0, 0, 0, 1, 1, z);
        cyc("post",  0, 1, 4, 5, 7, 0, 1, mk(0, 3'b001, pn(4, 0, 0), pm(7, 0, 0), 0, 0, 0));

        // pause freezes the countdown
        cyc("rst2",  1, 0, 0, 0, 0, 0, 0, z);
        cyc("ld7",   0, 1, 7, 2, 6, 0, 1, mk(0, 3'b001, pn(7, 0, 0), pm(6, 0, 0), 0, 0, 0));
        for (int i = 0; i < 5; i++)
            cyc("paus", 0, 0, 0, 0, 0, 1, 0, mk(0, 3'b001, pn(7, 0, 0), pm(6, 0, 0), 0, 0, 0));
        cyc("s4b1",  0, 0, 0, 0, 0, 1, 1, mk(0, 3'b001, pn(7, 0, 0), pm(6, 0, 0), 0, 0, 0));
        cyc("s4b2",  0, 0, 0, 0, 0, 1, 1, mk(0, 3'b000, 0, 0, 1, 3'b001, 0));
        cyc("dur0",  0, 1, 9, 0, 3, 0, 1, z);

        // one-voice build: strobe collides with the finishing beat
        cyc("rst1",  1, 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        cyc("v1ld",  0, 1, 9, 1, 2, 0, 1, mk(1, 1, 9, 2, 0, 0, 0));
        cyc("v1col", 0, 1, 13, 2, 1, 1, 1, mk(1, 0, 0, 0, 1, 1, 1));
        cyc("v1d0",  0, 1, 14, 0, 1, 0, 1, mk(1, 0, 0, 0, 0, 0, 0));
        cyc("v1idl", 0, 0, 0, 0, 0, 1, 1, mk(1, 0, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
